trap_sequencer: RTL
===================

# trap_sequencer

Parametrised trap controller for the RISC pipeline. It arbitrates `NUM_IRQ` level-sensitive interrupt sources and the illegal-instruction exception, and sequences trap entry and `mret` return. It drives the PC source select, holds the ID/EX flushes for a configurable number of cycles, and reports a registered trap cause to the CSR unit. It also blocks nested interrupts with a hardware in-handler flag that is set on trap entry and cleared on `mret`.

## Interface
Parameters:
- `NUM_IRQ`, 4: number of interrupt sources; index 0 has the highest priority.
- `CAUSE_W`, 4: width of the cause code; requires `NUM_IRQ <= 2**CAUSE_W`.
- `EXC_ILLEGAL`, 2: cause code reported for the illegal-instruction exception.
- `FLUSH_CYCLES`, 2: total cycles the flushes are held per trap entry or return; must be ≥1.

Ports:
- `i_clk`, in, 1: the single clock; all state changes on its rising edge.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `insn_vld`, in, 1: decoded instruction is legal; 0 requests the illegal-instruction exception.
- `mret`, in, 1: decoded instruction is `mret`.
- `mie`, in, 1: global interrupt enable (mstatus.MIE).
- `irq_en`, in, NUM_IRQ: per-source enables (mie CSR bits).
- `irq_pend`, in, NUM_IRQ: level interrupt requests (mip bits).
- `pc_src`, out, 2: PC select; 0 = RESET, 1 = TRAP, 2 = EPC, 3 = NEXT.
- `flush_ID`, out, 1: active-low flush of the ID stage.
- `flush_EX`, out, 1: active-low flush of the EX stage.
- `intr_en`, out, 1: one-cycle pulse; an interrupt trap is being taken.
- `excep_en`, out, 1: one-cycle pulse; an exception trap is being taken.
- `mret_status`, out, 1: one-cycle pulse; a trap return is in progress.
- `trap_cause`, out, CAUSE_W: registered cause code of the last trap.
- `trap_is_intr`, out, 1: registered flag; 1 = interrupt, 0 = exception.
- `in_handler`, out, 1: 1 from trap entry until `mret`.

## Operation
States:
- IDLE: entered on reset.
- RUN: normal execution.
- TRAP: trap entry, pc_src = TRAP.
- RET: trap return, pc_src = EPC.
- FLUSH: flush tail after TRAP or RET.

Interrupt arbitration:
- `irq_take = mie & ~in_handler & |(irq_pend & irq_en)`.
- The winning source is the lowest set index of `irq_pend & irq_en`.

Transitions:
- IDLE → RUN unconditionally.
- In RUN, checked in this priority order:
  - If `irq_take`, go to TRAP; register `trap_cause` = winner index, `trap_is_intr` = 1.
  - Else if `!insn_vld`, go to TRAP; register `trap_cause` = `EXC_ILLEGAL`, `trap_is_intr` = 0.
  - Else if `mret & in_handler`, go to RET.
  - Else if `mret & ~in_handler`, this is an illegal `mret`: go to TRAP as the illegal-instruction exception.
  - Else stay in RUN.
- TRAP and RET each last one cycle:
  - If `FLUSH_CYCLES = 1`, go to RUN.
  - Otherwise go to FLUSH and load the counter with `FLUSH_CYCLES-2`.
- FLUSH decrements the counter each cycle and goes to RUN on the cycle the counter reads 0.

Output values by state:
- IDLE: pc_src = RESET; flushes = 0 (flushing); pulses = 0.
- RUN: pc_src = NEXT; flushes = 1; pulses = 0.
- TRAP: pc_src = TRAP; flushes = 0; `intr_en` = `trap_is_intr`; `excep_en` = `~trap_is_intr`.
- RET: pc_src = EPC; flushes = 0; `mret_status` = 1.
- FLUSH: pc_src = NEXT; flushes = 0; pulses = 0.

`in_handler` behaviour:
- Set on the clock edge that enters TRAP.
- Cleared on the clock edge that enters RET.
- A nested exception while `in_handler` = 1 is still taken. The flag stays 1 and the cause is overwritten.

Inputs are ignored in TRAP, RET, FLUSH and IDLE. Level requests that are still pending are evaluated again on the first RUN cycle.

## Timing
Reset values of all outputs:
- `pc_src` = 0.
- `flush_ID` = `flush_EX` = 0.
- `intr_en` = `excep_en` = `mret_status` = 0.
- `trap_cause` = 0, `trap_is_intr` = 0, `in_handler` = 0.
- Internal state = IDLE, flush counter = 0.

Reset asserted mid-trap returns the block to IDLE immediately. All outputs take their reset values without waiting for a clock edge.

Latency:
- The RUN decision is combinational on the inputs and registered into the state.
- TRAP or RET is visible in the cycle after the request is sampled.
- All outputs decode from registered state and registered cause only. No input reaches an output combinationally.

Cycle counts:
- Flushes are low for exactly `FLUSH_CYCLES` consecutive cycles per trap or return, counting the TRAP/RET cycle.
- `trap_cause` and `trap_is_intr` are stable from the TRAP cycle until the next trap.

Back-to-back traps: if the IRQ is still pending after RET completes, it is taken on the first RUN cycle. The minimum spacing is then RET, FLUSH×(FLUSH_CYCLES−1), RUN, TRAP.

Simultaneous events:
- Interrupt and illegal instruction together: the interrupt wins.
- `mret` and an interrupt in the same cycle: the interrupt is masked by `in_handler` = 1, so `mret` wins.
- Several IRQs together: the lowest index wins.

## Test plan
- **Reset and idle:** hold `i_rst_n` = 0, then release. Required: pc_src = 0 with flushes = 0 for one cycle, then pc_src = 3 with flushes = 1.
- **Priority:** `NUM_IRQ` = 4, `mie` = 1, `irq_en` = 4'b1111, `irq_pend` = 4'b1010, `insn_vld` = 0 in the same cycle. Required: next cycle pc_src = 1, `intr_en` = 1, `trap_cause` = 1, `trap_is_intr` = 1, `excep_en` = 0.
- **Flush length:** `FLUSH_CYCLES` = 3, trap taken. Required: flushes low for exactly 3 cycles (TRAP plus 2 FLUSH), then pc_src = 3.
- **Nesting block:** in handler, `irq_pend` = 4'b0001 held. Required: no trap. `mret` pulse gives pc_src = 2 and `mret_status` = 1; the IRQ is taken on the first RUN cycle after the flush tail.
- **Illegal mret:** `mret` = 1 with `in_handler` = 0. Required: TRAP with `excep_en` = 1 and `trap_cause` = 2.
- **Async reset mid-FLUSH:** assert `i_rst_n` = 0 during FLUSH. Required: outputs at reset values within the same cycle; `in_handler` = 0.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap controller: arbitrates level interrupts and the illegal-instruction exception,
// sequences trap entry / mret return, holds ID/EX flushes and reports the trap cause.
module trap_sequencer #(
  parameter int NUM_IRQ      = 4,
  parameter int CAUSE_W      = 4,
  parameter int EXC_ILLEGAL  = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               insn_vld,
  input  logic               mret,
  input  logic               mie,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic [NUM_IRQ-1:0] irq_pend,
  output logic [1:0]         pc_src,
  output logic               flush_ID,
  output logic               flush_EX,
  output logic               intr_en,
  output logic               excep_en,
  output logic               mret_status,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic               trap_is_intr,
  output logic               in_handler
);

  localparam logic [1:0] PC_RESET = 2'd0;
  localparam logic [1:0] PC_TRAP  = 2'd1;
  localparam logic [1:0] PC_EPC   = 2'd2;
  localparam logic [1:0] PC_NEXT  = 2'd3;

  localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    TRAP  = 3'd2,
    RET   = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CAUSE_W-1:0] cause_next;
  logic               is_intr_next;
  logic               handler_next;

  logic [NUM_IRQ-1:0] irq_req;
  logic [CAUSE_W-1:0] winner;
  logic               irq_take;

  assign irq_req  = irq_pend & irq_en;
  assign irq_take = mie & ~in_handler & (|irq_req);

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) winner = CAUSE_W'(i);
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cause_next   = trap_cause;
    is_intr_next = trap_is_intr;
    handler_next = in_handler;
    case (state_reg)
      IDLE: state_next = RUN;
      RUN: begin
        if (irq_take) begin
          state_next   = TRAP;
          cause_next   = winner;
          is_intr_next = 1'b1;
          handler_next = 1'b1;
        end else if (!insn_vld || (mret && !in_handler)) begin
          // An mret outside a handler is treated as an illegal instruction.
          state_next   = TRAP;
          cause_next   = CAUSE_W'(EXC_ILLEGAL);
          is_intr_next = 1'b0;
          handler_next = 1'b1;
        end else if (mret) begin
          state_next   = RET;
          handler_next = 1'b0;
        end
      end
      TRAP, RET: begin
        if (FLUSH_CYCLES == 1) begin
          state_next = RUN;
        end else begin
          state_next = FLUSH;
          cnt_next   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (cnt_reg == '0) state_next = RUN;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they track state_reg exactly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      trap_cause   <= '0;
      trap_is_intr <= 1'b0;
      in_handler   <= 1'b0;
      pc_src       <= PC_RESET;
      flush_ID     <= 1'b0;
      flush_EX     <= 1'b0;
      intr_en      <= 1'b0;
      excep_en     <= 1'b0;
      mret_status  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      trap_cause   <= cause_next;
      trap_is_intr <= is_intr_next;
      in_handler   <= handler_next;
      case (state_next)
        IDLE:    pc_src <= PC_RESET;
        TRAP:    pc_src <= PC_TRAP;
        RET:     pc_src <= PC_EPC;
        default: pc_src <= PC_NEXT;
      endcase
      flush_ID    <= (state_next == RUN);
      flush_EX    <= (state_next == RUN);
      intr_en     <= (state_next == TRAP) &  is_intr_next;
      excep_en    <= (state_next == TRAP) & ~is_intr_next;
      mret_status <= (state_next == RET);
    end
  end

endmodule
